// File: rtl/lm70_read_scheduler.sv
// LM70 SPI read sequencer: periodic/one-shot requests, CS/SCK timing,
// frame capture, and a one-entry valid/ready output buffer with overrun flag.
`timescale 1ns/1ps
module lm70_read_scheduler #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned CS_GAP     = 4,
  parameter int unsigned PERIOD     = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  trig,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  sck,
  output logic                  busy,
  output logic [FRAME_BITS-1:0] sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  input  logic                  clr_ovr
);

  localparam int unsigned PHASE_LEN = 2 * CLK_DIV;
  localparam int unsigned MAX_A     = (CS_SETUP > PHASE_LEN) ? CS_SETUP : PHASE_LEN;
  localparam int unsigned MAX_B     = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int unsigned CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned PER_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(PHASE_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [PER_W-1:0]      per_cnt;
  logic                  pending;
  logic                  tick;
  logic                  leaving_idle;
  logic                  frame_done;
  logic                  accept;

  always_comb begin
    tick         = en && (per_cnt == PER_LAST);
    leaving_idle = (state == IDLE) && pending;
    frame_done   = (state == HOLD) && (cnt == HOLD_LAST);
    accept       = sample_valid && sample_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (!en || tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // A new request on the exit edge survives the clear, so it is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else begin
      pending <= trig || tick || (pending && !leaving_idle);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            state <= SETUP;
            cs_n  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state   <= SHIFT;
            cnt     <= '0;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == LOW_LAST) begin
            sck   <= 1'b1;
            shreg <= {shreg[FRAME_BITS-2:0], miso};
            cnt   <= cnt + 1'b1;
          end else if (cnt == HIGH_LAST) begin
            sck <= 1'b0;
            cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= GAP;
            cs_n  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cs_n  <= 1'b1;
          sck   <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A frame finishing on an accept edge replaces the old entry instead of dropping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (frame_done && (!sample_valid || sample_ready)) begin
        sample       <= shreg;
        sample_valid <= 1'b1;
      end else if (accept) begin
        sample_valid <= 1'b0;
      end
      if (frame_done && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lm70_read_scheduler.sv
// Scoreboard bench for lm70_read_scheduler: directed frames, periodic timer,
// overrun, request collapsing, mid-frame reset and same-edge replace.
`timescale 1ns/1ps
module tb_lm70_read_scheduler;

  logic        clk = 1'b0;
  logic        rst, en, trig, miso, sample_ready, clr_ovr;
  logic        cs_n, sck, busy, sample_valid, overrun;
  logic [15:0] sample;

  lm70_read_scheduler #(
    .CLK_DIV   (2),
    .FRAME_BITS(16),
    .CS_SETUP  (2),
    .CS_HOLD   (2),
    .CS_GAP    (4),
    .PERIOD    (200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .trig        (trig),
    .miso        (miso),
    .cs_n        (cs_n),
    .sck         (sck),
    .busy        (busy),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun),
    .clr_ovr     (clr_ovr)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] frame_word = '0;
  bit          check_period = 0;
  bit          check_b2b = 0;
  int          falls = 0;
  int          rises = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or event not expected", name);
  endtask

  // Monitor: sensor model on miso, frame timing checks, and scoreboard pops on accept.
  initial begin
    bit prev_cs, prev_sck, in_frame, measuring, sck_idle_bad;
    int cyc, low_cnt, gap_busy, period_ref, b2b_ref;
    prev_cs = 1; prev_sck = 0; in_frame = 0; measuring = 0; sck_idle_bad = 0;
    cyc = 0; low_cnt = 0; gap_busy = 0; period_ref = -1; b2b_ref = -1;
    miso = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!check_period) period_ref = -1;
      if (!check_b2b) b2b_ref = -1;
      if (rst) begin
        prev_cs = 1; prev_sck = 0; in_frame = 0; measuring = 0; sck_idle_bad = 0;
        rises = 0; low_cnt = 0; period_ref = -1; b2b_ref = -1;
        miso = 1'b0;
        continue;
      end
      if (cs_n && sck) sck_idle_bad = 1;
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got 0x%0h, none expected", sample);
        end else begin
          chk("sample", {16'h0, sample}, {16'h0, exp_q.pop_front()});
        end
      end
      if (prev_cs && !cs_n) begin
        falls++;
        in_frame = 1; rises = 0; low_cnt = 0;
        if (check_period) begin
          if (period_ref >= 0) chk("cs_fall_period", cyc - period_ref, 200);
          period_ref = cyc;
        end
        if (check_b2b && b2b_ref >= 0) chk("cs_rise_to_next_fall", cyc - b2b_ref, 5);
      end
      if (!cs_n) low_cnt++;
      if (in_frame && sck && !prev_sck) rises++;
      if (in_frame && !prev_cs && cs_n) begin
        chk("cs_low_cycles", low_cnt, 68);
        chk("sck_rises", rises, 16);
        chk("valid_at_cs_rise", {31'h0, sample_valid}, 1);
        chk("sck_toggle_while_cs_high", {31'h0, sck_idle_bad}, 0);
        sck_idle_bad = 0;
        in_frame = 0; measuring = 1; gap_busy = 0;
        if (check_b2b) b2b_ref = cyc;
      end
      if (measuring) begin
        if (busy) gap_busy++;
        else begin
          chk("gap_busy_cycles", gap_busy, 4);
          measuring = 0;
        end
      end
      miso = (in_frame && rises < 16) ? frame_word[15 - rises] : 1'b0;
      prev_cs = cs_n; prev_sck = sck;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step(1);
    trig = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int n = 0;
    while (!busy && n < budget) begin step(1); n++; end
    if (!busy) fail("frame_start_timeout");
    else begin
      n = 0;
      while (busy && n < budget) begin step(1); n++; end
      if (busy) fail("frame_done_timeout");
    end
  endtask

  task automatic wait_cs_low(input int budget);
    int n = 0;
    while (cs_n && n < budget) begin step(1); n++; end
    if (cs_n) fail("cs_low_timeout");
  endtask

  initial begin
    int f0;
    int n;
    rst = 1'b1; en = 1'b0; trig = 1'b0; sample_ready = 1'b0; clr_ovr = 1'b0;
    step(3);
    chk("rst_cs_n", {31'h0, cs_n}, 1);
    chk("rst_sck", {31'h0, sck}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_sample", {16'h0, sample}, 0);
    chk("rst_valid", {31'h0, sample_valid}, 0);
    chk("rst_overrun", {31'h0, overrun}, 0);
    rst = 1'b0;
    step(3);
    chk("idle_no_request_cs_n", {31'h0, cs_n}, 1);

    // 1: single triggered frame
    sample_ready = 1'b1;
    frame_word = 16'h0C9F;
    exp_q.push_back(16'h0C9F);
    pulse_trig();
    wait_frame(200);
    step(2);
    chk("t1_valid_after_accept", {31'h0, sample_valid}, 0);

    // 2: periodic requests
    check_period = 1;
    frame_word = 16'hA5C3;
    repeat (3) exp_q.push_back(16'hA5C3);
    en = 1'b1;
    repeat (3) wait_frame(400);
    en = 1'b0;
    check_period = 0;
    chk("t2_overrun", {31'h0, overrun}, 0);

    // 3: consumer stalled, second frame dropped
    step(5);
    sample_ready = 1'b0;
    frame_word = 16'h1234;
    pulse_trig();
    wait_frame(200);
    frame_word = 16'h5678;
    pulse_trig();
    wait_frame(200);
    chk("t3_sample_kept", {16'h0, sample}, 16'h1234);
    chk("t3_overrun_set", {31'h0, overrun}, 1);
    chk("t3_valid_held", {31'h0, sample_valid}, 1);
    exp_q.push_back(16'h1234);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    chk("t3_overrun_cleared", {31'h0, overrun}, 0);
    sample_ready = 1'b1;
    step(1);
    chk("t3_valid_dropped", {31'h0, sample_valid}, 0);

    // 4: requests during a frame collapse into exactly one more frame
    check_b2b = 1;
    frame_word = 16'h3C5A;
    exp_q.push_back(16'h3C5A);
    exp_q.push_back(16'h3C5A);
    f0 = falls;
    pulse_trig();
    wait_cs_low(20);
    repeat (3) begin
      step(10);
      pulse_trig();
    end
    wait_frame(200);
    wait_frame(200);
    check_b2b = 0;
    step(100);
    chk("t4_frames_started", falls - f0, 2);
    chk("t4_idle_after", {31'h0, busy}, 0);

    // 5: reset during SHIFT
    frame_word = 16'hBEEF;
    pulse_trig();
    n = 0;
    while (rises < 7 && n < 300) begin step(1); n++; end
    if (rises < 7) fail("t5_shift_timeout");
    #2 rst = 1'b1;
    #1;
    chk("t5_async_cs_n", {31'h0, cs_n}, 1);
    chk("t5_async_sck", {31'h0, sck}, 0);
    chk("t5_async_busy", {31'h0, busy}, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    step(3);
    chk("t5_no_valid", {31'h0, sample_valid}, 0);
    frame_word = 16'h8001;
    exp_q.push_back(16'h8001);
    pulse_trig();
    wait_frame(200);
    step(2);

    // 6: accept and load on the same edge
    sample_ready = 1'b0;
    frame_word = 16'h1111;
    exp_q.push_back(16'h1111);
    pulse_trig();
    wait_frame(200);
    frame_word = 16'h2222;
    exp_q.push_back(16'h2222);
    pulse_trig();
    wait_cs_low(20);
    step(67);
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    chk("t6_cs_n_rose", {31'h0, cs_n}, 1);
    chk("t6_valid_stays", {31'h0, sample_valid}, 1);
    chk("t6_new_sample", {16'h0, sample}, 16'h2222);
    chk("t6_overrun", {31'h0, overrun}, 0);
    wait_frame(50);
    sample_ready = 1'b1;
    step(2);
    chk("t6_valid_after_accept", {31'h0, sample_valid}, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lm70_read_scheduler.md
Name: lm70_read_scheduler

Overview:
- Sequences SPI read frames from the LM70 temperature sensor.
- Generates CS and SCK with programmable timing and captures one MISO frame per transaction.
- Requests come from a periodic timer or a one-shot trigger.
- Delivers each frame over a valid/ready handshake to the display/conversion datapath, and flags samples dropped because the consumer stalled.

Parameters:
- CLK_DIV, 2: clk cycles per SCK half-period (>=1).
- FRAME_BITS, 16: SCK rising edges per frame (2..32).
- CS_SETUP, 2: cycles cs_n is low before the first SCK rise phase (>=1).
- CS_HOLD, 2: cycles cs_n stays low after the last SCK fall (>=1).
- CS_GAP, 4: minimum cycles cs_n is high between frames (>=1).
- PERIOD, 200: clk cycles between periodic requests. Must exceed the frame length plus CS_GAP.

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- rst, input, 1: reset, asynchronous, active-high.
- en, input, 1: enables the periodic timer.
- trig, input, 1: one-shot read request, sampled each cycle.
- miso, input, 1: serial data from the sensor (SIO).
- cs_n, output, 1: chip select, active-low, registered.
- sck, output, 1: SPI clock, registered, idles low.
- busy, output, 1: high whenever state != IDLE.
- sample, output, FRAME_BITS: last captured frame, MSB = first bit received.
- sample_valid, output, 1: sample holds unconsumed data.
- sample_ready, input, 1: consumer accepts sample when sample_valid && sample_ready.
- overrun, output, 1: sticky; a completed frame was dropped.
- clr_ovr, input, 1: synchronous clear of overrun.

Behaviour:
- Reset values: cs_n=1, sck=0, busy=0, sample=0, sample_valid=0, overrun=0. Also cleared: state=IDLE, pending=0, period counter=0, shift register=0.
- Reset is asynchronous. If asserted mid-frame, cs_n rises and sck drops immediately. The partial frame is discarded.
- Period counter:
  - While en=1, counts 0..PERIOD-1 and wraps; the wrap cycle produces a tick.
  - en=0 holds the counter at 0 and produces no tick.
  - Clearing en does not abort an in-flight frame.
- pending flag:
  - Set by trig=1 or by a tick, in any state.
  - Cleared on the edge that leaves IDLE.
  - Multiple requests collapse into one.
  - If a request arrives on the same cycle IDLE is exited, pending stays set.
- States:
  - IDLE: cs_n=1, sck=0. If pending, go to SETUP; cs_n goes low on that same edge.
  - SETUP: CS_SETUP cycles with sck=0, then SHIFT.
  - SHIFT: FRAME_BITS bit periods of 2*CLK_DIV cycles each: CLK_DIV cycles sck=0, then CLK_DIV cycles sck=1.
    - miso is shifted in (left shift, into LSB) on the edge that drives sck 0->1.
    - After the last high half, sck returns low and the state goes to HOLD.
  - HOLD: CS_HOLD cycles with cs_n=0, sck=0.
    - On exit, cs_n goes high and the frame completes (see output buffer) on the same edge.
    - Then GAP.
  - GAP: CS_GAP cycles with cs_n=1, then IDLE.
- Frame timing: cs_n is low for exactly CS_SETUP + 2*CLK_DIV*FRAME_BITS + CS_HOLD cycles (68 at defaults). Requested-to-cs_n-low latency is 1 cycle from pending seen in IDLE.
- Output buffer (one entry) at frame completion:
  - If sample_valid=0, or sample_valid && sample_ready in that cycle: load sample, set sample_valid=1.
  - Otherwise: discard the new frame, keep the old sample, set overrun=1.
- Handshake:
  - sample_valid deasserts on an accept edge unless a new frame loads on the same edge.
  - sample is stable while sample_valid=1 and not accepted.
- overrun: clr_ovr clears it. If a clear and a new overrun coincide, overrun stays set.
- sck never toggles while cs_n=1.

Test Plan:
1. Defaults, en=0, one trig pulse, miso driving 0x0C9F MSB-first on sck falls → cs_n low for 68 cycles, 16 sck rises, then sample=0x0C9F and sample_valid=1 on the edge cs_n rises. busy low after 4 GAP cycles.
2. en=1, trig=0, sample_ready=1 held → cs_n falling edges exactly 200 cycles apart; each frame delivered once; overrun stays 0.
3. sample_ready=0, two trig-initiated frames 0x1234 then 0x5678 → sample stays 0x1234, overrun=1. clr_ovr pulse clears overrun, then ready=1 accepts 0x1234 and valid drops.
4. trig pulsed 3 times during one frame → exactly one further frame, starting CS_GAP+1 cycles after cs_n rises.
5. rst pulsed at SHIFT bit 7 → cs_n=1, sck=0 asynchronously, no sample_valid. Next trig yields a clean full frame.
6. sample_valid=1 with sample_ready=1 on the same cycle a frame completes → new sample loaded, sample_valid stays 1, overrun=0.
